crc8_frame_tx: RTL and testbench

Bit-serial frame transmitter that feeds the serial CRC-8 link. It accepts payload bytes over a valid/ready byte stream and serialises each byte MSB-first onto a 1-bit output. It computes CRC-8-CCITT (poly x^8+x^2+x+1, non-reflected) over the payload bits on the fly and appends the 8-bit CRC MSB-first at end of frame. The bit stream it produces is the exact din/enable sequence a downstream serial CRC checker consumes; a correct frame leaves that checker's register at zero.

---
 rtl/crc8_pkg.sv | 22 ++
 rtl/crc8_frame_tx_if.sv | 24 ++
 rtl/crc8_serial_acc.sv | 31 +++
 rtl/crc8_frame_tx.sv | 146 ++++++++++++++
 tb/tb_crc8_frame_tx.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crc8_pkg.sv
// Shared definitions for the serial CRC-8-CCITT link (poly x^8+x^2+x+1, MSB-first, non-reflected).
// Both the frame transmitter and the downstream checker use crc8_step, so they cannot disagree.
package crc8_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_WAIT = 3'd2,
    ST_CRC  = 3'd3,
    ST_GAP  = 3'd4
  } tx_state_e;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_frame_tx_if.sv
// Byte stream in, bit stream out, for the CRC-8 frame transmitter.
interface crc8_frame_tx_if;
  // Byte side: a beat transfers on a rising edge where s_valid & s_ready are both 1.
  // s_data/s_last are only meaningful while s_valid=1; the source holds them until accepted.
  // Bit side has no back-pressure: tx_bit is a frame bit exactly in cycles with tx_valid=1.
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic       tx_bit;
  logic       tx_valid;
  logic       tx_sof;
  logic       tx_eof;

  modport slave (
    input  s_data, s_valid, s_last,
    output s_ready, tx_bit, tx_valid, tx_sof, tx_eof
  );

  modport master (
    output s_data, s_valid, s_last,
    input  s_ready, tx_bit, tx_valid, tx_sof, tx_eof
  );
endinterface

// File: rtl/crc8_serial_acc.sv
// Serial CRC-8 register: init has priority over enable, one bit per enabled cycle.
module crc8_serial_acc
  import crc8_pkg::*;
#(
  parameter logic [7:0] INIT = CRC8_INIT
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       init_i,
  input  logic       en_i,
  input  logic       din_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init_i)    crc_d = INIT;
    else if (en_i) crc_d = crc8_step(crc_q, din_i);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) crc_q <= INIT;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/crc8_frame_tx.sv
// Bit-serial frame transmitter: payload bytes MSB-first, then the running CRC-8 MSB-first,
// then a fixed inter-frame gap. All outputs decode registered state only.
module crc8_frame_tx
  import crc8_pkg::*;
#(
  parameter logic [7:0]  CRC_INIT   = CRC8_INIT,
  parameter logic [7:0]  CRC_XOROUT = 8'h00,
  parameter int unsigned IFG_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rstb,
  crc8_frame_tx_if.slave     bus,
  output logic               busy_o,
  output tx_state_e          state_o
);

  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  tx_state_e     state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    crc_tx_q, crc_tx_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          last_q, last_d;
  logic          first_q, first_d;

  logic          ready;
  logic          accept;
  logic          crc_init;
  logic          crc_en;
  logic [7:0]    crc_cur;

  // Ready never looks at s_valid, so there is no s_valid -> output path.
  assign ready  = (state_q == ST_IDLE) || (state_q == ST_WAIT) ||
                  ((state_q == ST_DATA) && (bit_cnt_q == 3'd7) && !last_q);
  assign accept = bus.s_valid && ready;

  crc8_serial_acc #(.INIT(CRC_INIT)) u_acc (
    .clk    (clk),
    .rstb   (rstb),
    .init_i (crc_init),
    .en_i   (crc_en),
    .din_i  (shreg_q[7]),
    .crc_o  (crc_cur)
  );

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    crc_tx_d     = crc_tx_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    last_d       = last_q;
    first_d      = first_q;
    crc_init     = 1'b0;
    crc_en       = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_bit   = 1'b0;
    bus.tx_sof   = 1'b0;
    bus.tx_eof   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d   = bus.s_data;
          last_d    = bus.s_last;
          bit_cnt_d = 3'd0;
          first_d   = 1'b1;
          crc_init  = 1'b1;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        bus.tx_valid = 1'b1;
        bus.tx_bit   = shreg_q[7];
        bus.tx_sof   = first_q;
        first_d      = 1'b0;
        crc_en       = 1'b1;
        shreg_d      = {shreg_q[6:0], 1'b0};
        bit_cnt_d    = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (last_q) begin
            // Fold in this cycle's bit so the CRC is ready for the very next cycle.
            crc_tx_d = crc8_step(crc_cur, shreg_q[7]) ^ CRC_XOROUT;
            state_d  = ST_CRC;
          end else if (accept) begin
            shreg_d = bus.s_data;
            last_d  = bus.s_last;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (accept) begin
          shreg_d   = bus.s_data;
          last_d    = bus.s_last;
          bit_cnt_d = 3'd0;
          state_d   = ST_DATA;
        end
      end
      ST_CRC: begin
        bus.tx_valid = 1'b1;
        bus.tx_bit   = crc_tx_q[7];
        crc_tx_d     = {crc_tx_q[6:0], 1'b0};
        bit_cnt_d    = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          bus.tx_eof = 1'b1;
          gap_cnt_d  = '0;
          state_d    = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      crc_tx_q  <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      last_q    <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      crc_tx_q  <= crc_tx_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      last_q    <= last_d;
      first_q   <= first_d;
    end
  end

  assign bus.s_ready = ready;
  assign busy_o      = (state_q != ST_IDLE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_crc8_frame_tx.sv
// Bench for crc8_frame_tx: byte driver, bit monitor with reference serial checker,
// byte scoreboard and timing checks against accept cycles.
module tb_crc8_frame_tx;
  import crc8_pkg::*;

  logic      clk;
  logic      rstb;
  logic      busy;
  tx_state_e state;

  crc8_frame_tx_if bus ();

  crc8_frame_tx #(
    .CRC_INIT   (8'hFF),
    .CRC_XOROUT (8'h00),
    .IFG_CYCLES (2)
  ) dut (
    .clk     (clk),
    .rstb    (rstb),
    .bus     (bus.slave),
    .busy_o  (busy),
    .state_o (state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] frame_b[0:15];

  // results published by the monitor at each tx_eof
  int         frames_done = 0;
  int         sof_cyc, eof_cyc, res_valid, res_idle;
  logic [7:0] res_crc;
  int         t0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, got no end expected end");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  function automatic logic [7:0] ref_crc(input int n);
    logic [7:0] c;
    logic [7:0] d;
    c = 8'hFF;
    for (int i = 0; i < n; i++) begin
      d = frame_b[i];
      for (int k = 7; k >= 0; k--) c = ref_step(c, d[k]);
    end
    return c;
  endfunction

  // ---------------- driver ----------------
  task automatic send_frame(input int n, input int gap);
    int t_acc;
    int waited;
    t_acc = 0;
    for (int i = 0; i < n; i++) exp_q.push_back(frame_b[i]);
    exp_q.push_back(ref_crc(n));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0 && gap > 0) begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'($urandom_range(0, 255));
        bus.s_last  = 1'($urandom_range(0, 1));
        while (cyc < t_acc + 8 + gap) @(negedge clk);
      end
      bus.s_data  = frame_b[i];
      bus.s_last  = (i == n - 1);
      bus.s_valid = 1'b1;
      waited = 0;
      while (!bus.s_ready && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      if (!bus.s_ready) begin
        check_eq("accept_timeout", 32'd0, 32'd1);
        bus.s_valid = 1'b0;
        return;
      end
      t_acc = cyc;
      if (i == 0) t0 = cyc;
      @(posedge clk);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_data  = 8'($urandom_range(0, 255));
    bus.s_last  = 1'b1;
  endtask

  task automatic wait_frame(input int target);
    int waited;
    waited = 0;
    while (frames_done < target && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check_eq("frame_timeout", 32'(frames_done >= target), 32'd1);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // ---------------- monitor + scoreboard ----------------
  logic [7:0] ref_chk;
  logic [7:0] cur_byte;
  int         bit_n, f_valid, f_idle;
  bit         in_frame;

  always @(negedge clk) begin
    if (!rstb) begin
      bit_n    = 0;
      in_frame = 1'b0;
      f_valid  = 0;
      f_idle   = 0;
    end else if (bus.tx_valid) begin
      if (bus.tx_sof) begin
        ref_chk  = 8'hFF;
        in_frame = 1'b1;
        sof_cyc  = cyc;
        f_valid  = 0;
        f_idle   = 0;
        bit_n    = 0;
      end
      f_valid++;
      ref_chk  = ref_step(ref_chk, bus.tx_bit);
      cur_byte = {cur_byte[6:0], bus.tx_bit};
      bit_n++;
      if (bit_n == 8) begin
        bit_n = 0;
        if (exp_q.size() == 0) check_eq("unexpected_byte", {24'd0, cur_byte}, 32'hFFFF_FFFF);
        else                   check_eq("tx_byte", {24'd0, cur_byte}, {24'd0, exp_q.pop_front()});
      end
      if (bus.tx_eof) begin
        check_eq("checker_zero", {24'd0, ref_chk}, 32'd0);
        check_eq("eof_aligned", bit_n, 0);
        eof_cyc   = cyc;
        res_valid = f_valid;
        res_idle  = f_idle;
        res_crc   = cur_byte;
        in_frame  = 1'b0;
        frames_done++;
      end
    end else begin
      if (in_frame) f_idle++;
      check_eq("idle_outputs", {29'd0, bus.tx_bit, bus.tx_sof, bus.tx_eof}, 32'd0);
    end
  end

  // ---------------- tests ----------------
  task automatic single_byte(input logic [7:0] b, input logic [7:0] crc_exp, input string tag);
    int fd;
    fd = frames_done;
    frame_b[0] = b;
    send_frame(1, 0);
    wait_frame(fd + 1);
    check_eq({tag, "_crc"}, {24'd0, res_crc}, {24'd0, crc_exp});
    check_eq({tag, "_sof"}, sof_cyc, t0 + 1);
    check_eq({tag, "_eof"}, eof_cyc, t0 + 16);
    check_eq({tag, "_valid"}, res_valid, 16);
  endtask

  logic [7:0] crc_nostall;

  initial begin
    rstb        = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check_eq("rst_tx_bit", {31'd0, bus.tx_bit}, 32'd0);
    check_eq("rst_sof_eof", {30'd0, bus.tx_sof, bus.tx_eof}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_ready", {31'd0, bus.s_ready}, 32'd1);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    // single bytes with known CRCs, plus gap/busy timing after the first
    single_byte(8'h00, 8'hF3, "b00");
    wait_cyc(eof_cyc + 1);
    check_eq("gap1_busy", {31'd0, busy}, 32'd1);
    check_eq("gap1_ready", {31'd0, bus.s_ready}, 32'd0);
    wait_cyc(eof_cyc + 2);
    check_eq("gap2_busy", {31'd0, busy}, 32'd1);
    wait_cyc(eof_cyc + 3);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    check_eq("idle_ready", {31'd0, bus.s_ready}, 32'd1);
    single_byte(8'h01, 8'hF4, "b01");
    single_byte(8'hFF, 8'h00, "bFF");

    // two bytes back to back
    frame_b[0] = 8'hFF;
    frame_b[1] = 8'h00;
    begin
      int fd;
      fd = frames_done;
      send_frame(2, 0);
      wait_frame(fd + 1);
    end
    check_eq("b2b_valid", res_valid, 24);
    check_eq("b2b_bubbles", res_idle, 0);
    check_eq("b2b_eof", eof_cyc, t0 + 24);
    check_eq("b2b_crc", {24'd0, res_crc}, {24'd0, ref_crc(2)});
    crc_nostall = res_crc;

    // same frame, second byte withheld for 5 cycles
    begin
      int fd;
      fd = frames_done;
      send_frame(2, 5);
      wait_frame(fd + 1);
    end
    check_eq("stall_idle", res_idle, 5);
    check_eq("stall_valid", res_valid, 24);
    check_eq("stall_eof", eof_cyc, t0 + 29);
    check_eq("stall_crc", {24'd0, res_crc}, {24'd0, crc_nostall});

    // random frames
    for (int f = 0; f < 20; f++) begin
      int n, g, fd;
      n  = $urandom_range(1, 16);
      g  = $urandom_range(0, 3);
      fd = frames_done;
      for (int i = 0; i < n; i++) frame_b[i] = 8'($urandom_range(0, 255));
      send_frame(n, g);
      wait_frame(fd + 1);
      check_eq("rnd_valid", res_valid, 8 * n + 8);
      check_eq("rnd_idle", res_idle, g * (n - 1));
      check_eq("rnd_eof", eof_cyc, t0 + 8 * n + 8 + g * (n - 1));
    end

    // reset in the middle of the CRC field
    frame_b[0] = 8'hA5;
    send_frame(1, 0);
    wait_cyc(t0 + 12);
    rstb = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, bus.tx_valid}, 32'd0);
    check_eq("mid_rst_bit", {31'd0, bus.tx_bit}, 32'd0);
    check_eq("mid_rst_sof_eof", {30'd0, bus.tx_sof, bus.tx_eof}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_ready", {31'd0, bus.s_ready}, 32'd1);
    check_eq("mid_rst_state", {29'd0, state}, {29'd0, ST_IDLE});
    repeat (2) @(negedge clk);
    exp_q.delete();
    rstb = 1'b1;
    repeat (2) @(negedge clk);
    single_byte(8'h00, 8'hF3, "post_rst");

    repeat (5) @(negedge clk);
    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
